// File: rtl/cordic_rotation.sv
// Fully pipelined rotation-mode CORDIC with quadrant pre-rotation and gain compensation.
// Angles are in degrees; every word is signed Q(N.M), one vector accepted per clock.
module cordic_rotation #(
    parameter int N     = 9,
    parameter int M     = 23,
    parameter int STEPS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic signed [N+M-1:0] i_x,
    input  logic signed [N+M-1:0] i_y,
    input  logic signed [N+M-1:0] i_alpha,
    output logic signed [N+M-1:0] o_x,
    output logic signed [N+M-1:0] o_y,
    output logic                  o_valid
);

    localparam int W    = N + M;
    localparam int XW   = W + 2;
    localparam int PW   = XW + W;
    localparam int NREG = (STEPS > 1) ? STEPS - 1 : 1;

    function automatic logic signed [N+M-1:0] to_q(input real r);
        real    scale;
        longint v;
        scale = 1.0;
        for (int k = 0; k < M; k++) scale = scale * 2.0;
        v = longint'(r * scale);
        return v[N+M-1:0];
    endfunction

    // atan(2^-i) in degrees via its Taylor series; t <= 0.5 for i >= 1 so 40 terms is ample
    function automatic real atan_deg(input int i);
        real t, term, sum;
        if (i == 0) return 45.0;
        t = 1.0;
        for (int k = 0; k < i; k++) t = t / 2.0;
        sum  = 0.0;
        term = t;
        for (int k = 0; k < 40; k++) begin
            sum  = (k % 2 == 1) ? sum - term / real'(2 * k + 1) : sum + term / real'(2 * k + 1);
            term = term * t * t;
        end
        return sum * 180.0 / 3.14159265358979323846;
    endfunction

    function automatic real gain_k(input int n);
        real p, t, s;
        p = 1.0;
        t = 1.0;
        for (int k = 0; k < n; k++) begin
            p = p / (1.0 + t);
            t = t / 4.0;
        end
        s = 1.0;
        for (int k = 0; k < 40; k++) s = 0.5 * (s + p / s);
        return s;
    endfunction

    localparam logic signed [W-1:0]  DEG90  = to_q(90.0);
    localparam logic signed [W-1:0]  NEG90  = to_q(-90.0);
    localparam logic signed [W-1:0]  K_Q    = to_q(gain_k(STEPS));
    localparam logic signed [PW-1:0] MAXV   = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV   = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic [N+M-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV) return MAXV[W-1:0];
        if (v < MINV) return MINV[W-1:0];
        return v[W-1:0];
    endfunction

    logic signed [XW-1:0] x_in [STEPS];
    logic signed [XW-1:0] y_in [STEPS];
    logic signed [W-1:0]  z_in [STEPS];
    logic signed [XW-1:0] x_d  [STEPS];
    logic signed [XW-1:0] y_d  [STEPS];
    logic signed [W-1:0]  z_d  [NREG];
    logic                 v_d  [STEPS];

    logic signed [XW-1:0] x_q [NREG];
    logic signed [XW-1:0] y_q [NREG];
    logic signed [W-1:0]  z_q [NREG];
    logic                 v_q [NREG];

    logic signed [XW-1:0] pre_x, pre_y, ext_x, ext_y;
    logic signed [W-1:0]  pre_z;

    always_comb begin
        ext_x = {{2{i_x[W-1]}}, i_x};
        ext_y = {{2{i_y[W-1]}}, i_y};
        pre_x = ext_x;
        pre_y = ext_y;
        pre_z = i_alpha;
        if (i_alpha > DEG90) begin
            pre_x = -ext_y;
            pre_y = ext_x;
            pre_z = i_alpha - DEG90;
        end else if (i_alpha < NEG90) begin
            pre_x = ext_y;
            pre_y = -ext_x;
            pre_z = i_alpha + DEG90;
        end
    end

    for (genvar g = 0; g < STEPS; g++) begin : g_stage
        localparam logic signed [W-1:0] ATAN_I = to_q(atan_deg(g));

        if (g == 0) begin : g_first
            assign x_in[g] = pre_x;
            assign y_in[g] = pre_y;
            assign z_in[g] = pre_z;
            assign v_d[g]  = i_en;
        end else begin : g_next
            assign x_in[g] = x_q[g-1];
            assign y_in[g] = y_q[g-1];
            assign z_in[g] = z_q[g-1];
            assign v_d[g]  = v_q[g-1];
        end

        assign x_d[g] = (z_in[g] >= 0) ? x_in[g] - (y_in[g] >>> g) : x_in[g] + (y_in[g] >>> g);
        assign y_d[g] = (z_in[g] >= 0) ? y_in[g] + (x_in[g] >>> g) : y_in[g] - (x_in[g] >>> g);

        // The last iteration feeds the gain multiplier, so its residual angle is never needed
        if (g < STEPS - 1) begin : g_z
            assign z_d[g] = (z_in[g] >= 0) ? z_in[g] - ATAN_I : z_in[g] + ATAN_I;
        end
    end

    logic signed [PW-1:0] xm, ym, km, prod_x, prod_y;
    logic signed [W-1:0]  o_x_d, o_y_d, o_x_q, o_y_q;
    logic                 o_valid_q;

    always_comb begin
        xm     = {{(PW-XW){x_d[STEPS-1][XW-1]}}, x_d[STEPS-1]};
        ym     = {{(PW-XW){y_d[STEPS-1][XW-1]}}, y_d[STEPS-1]};
        km     = {{(PW-W){K_Q[W-1]}}, K_Q};
        prod_x = (xm * km) >>> M;
        prod_y = (ym * km) >>> M;
        o_x_d  = o_x_q;
        o_y_d  = o_y_q;
        if (v_d[STEPS-1]) begin
            o_x_d = sat(prod_x);
            o_y_d = sat(prod_y);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < NREG; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
                v_q[k] <= 1'b0;
            end
            o_x_q     <= '0;
            o_y_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < STEPS - 1; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                z_q[k] <= z_d[k];
                v_q[k] <= v_d[k];
            end
            o_x_q     <= o_x_d;
            o_y_q     <= o_y_d;
            o_valid_q <= v_d[STEPS-1];
        end
    end

    assign o_x     = o_x_q;
    assign o_y     = o_y_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed bench for cordic_rotation: reset, latency, pre-rotation corners, saturation,
// back-to-back streaming against a real-valued model, and reset with data in flight.
module tb_cordic_rotation;

    localparam int  STEPS = 10;
    localparam real SCALE = 8388608.0;
    localparam real PI    = 3.14159265358979323846;

    logic        i_clk;
    logic        i_reset;
    logic        i_en;
    logic [31:0] i_x, i_y, i_alpha;
    logic [31:0] o_x, o_y;
    logic        o_valid;

    int checks;
    int failures;
    logic [31:0] last_x, last_y;

    logic [31:0] sx [20];
    logic [31:0] sy [20];
    logic [31:0] sa [20];
    real         ex [20];
    real         ey [20];
    real         tv [20];

    cordic_rotation #(.N(9), .M(23), .STEPS(STEPS)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_alpha (i_alpha),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_valid (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] q(input real r);
        longint v;
        v = longint'(r * SCALE);
        return v[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] got, input real exp, input real tol);
        real g;
        g = real'($signed(got)) / SCALE;
        checks++;
        assert ((g - exp <= tol) && (exp - g <= tol)) else begin
            failures++;
            $error("FAIL %s got=%f exp=%f tol=%f", tag, g, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check_eq({tag, "_x"}, o_x, 32'd0);
        check_eq({tag, "_y"}, o_y, 32'd0);
    endtask

    task automatic send_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] a, input real rx, input real ry, input real tol);
        int lat;
        i_x     = x;
        i_y     = y;
        i_alpha = a;
        i_en    = 1'b1;
        tick();
        i_en = 1'b0;
        lat  = 0;
        while (!o_valid && lat < 30) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, STEPS - 1);
        check_near({tag, "_x"}, o_x, rx, tol);
        check_near({tag, "_y"}, o_y, ry, tol);
        last_x = o_x;
        last_y = o_y;
        tick();
        check_eq({tag, "_pulse"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int rx_cnt, first, last, nval;
        real xr, yr, ar;

        checks   = 0;
        failures = 0;
        i_reset  = 1'b0;
        i_en     = 1'b0;
        i_x      = '0;
        i_y      = '0;
        i_alpha  = '0;

        repeat (10) begin
            tick();
            chk_zero("rst_during");
        end
        i_reset = 1'b1;
        tick();
        chk_zero("rst_after");

        send_one("rot90",  q(1.0), q(1.0), q(90.0),   -1.0,       1.0,       0.01);
        send_one("a0",     q(1.0), 32'd0,  32'd0,      1.0,       0.0,       0.01);
        send_one("am30",   q(1.0), 32'd0,  q(-30.0),   0.8660254, -0.5,      0.01);
        send_one("a180",   q(1.0), 32'd0,  q(180.0),  -1.0,       0.0,       0.01);
        send_one("am180",  q(1.0), 32'd0,  q(-180.0), -1.0,       0.0,       0.01);
        send_one("a135",   q(1.0), 32'd0,  q(135.0),  -0.7071068, 0.7071068, 0.01);
        send_one("am135",  q(1.0), 32'd0,  q(-135.0), -0.7071068, -0.7071068, 0.01);

        // (255,255) rotated onto an axis has magnitude ~360.6, beyond the Q9.23 range
        send_one("sat_pos", q(255.0), q(255.0), q(45.0), 0.0, 255.9999999, 1.0);
        check_eq("sat_pos_exact", last_y, 32'h7FFF_FFFF);
        send_one("sat_neg", q(255.0), q(255.0), q(-135.0), 0.0, -256.0, 1.0);
        check_eq("sat_neg_exact", last_y, 32'h8000_0000);

        for (int k = 0; k < 20; k++) begin
            sx[k] = $urandom_range(32'd1677721600, 32'd0) - 32'd838860800;
            sy[k] = $urandom_range(32'd1677721600, 32'd0) - 32'd838860800;
            sa[k] = $urandom_range(32'd3019898880, 32'd0) - 32'd1509949440;
            xr    = real'($signed(sx[k])) / SCALE;
            yr    = real'($signed(sy[k])) / SCALE;
            ar    = real'($signed(sa[k])) / SCALE * PI / 180.0;
            ex[k] = xr * $cos(ar) - yr * $sin(ar);
            ey[k] = xr * $sin(ar) + yr * $cos(ar);
            tv[k] = 0.005 * $sqrt(xr * xr + yr * yr) + 0.01;
        end

        rx_cnt = 0;
        first  = -1;
        last   = -1;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) begin
                i_x     = sx[c];
                i_y     = sy[c];
                i_alpha = sa[c];
                i_en    = 1'b1;
            end else begin
                i_en = 1'b0;
            end
            tick();
            if (o_valid) begin
                if (rx_cnt == 0) first = c;
                if (rx_cnt < 20) begin
                    check_near($sformatf("stream%0d_x", rx_cnt), o_x, ex[rx_cnt], tv[rx_cnt]);
                    check_near($sformatf("stream%0d_y", rx_cnt), o_y, ey[rx_cnt], tv[rx_cnt]);
                end
                rx_cnt++;
                last = c;
            end
        end
        check_eq("stream_count", rx_cnt, 32'd20);
        check_eq("stream_first", first, STEPS - 1);
        check_eq("stream_contig", last - first + 1, 32'd20);

        for (int k = 0; k < 5; k++) begin
            i_x     = sx[k];
            i_y     = sy[k];
            i_alpha = sa[k];
            i_en    = 1'b1;
            tick();
        end
        i_en = 1'b0;
        #2;
        i_reset = 1'b0;
        #1;
        chk_zero("rst_mid_async");
        tick();
        tick();
        i_reset = 1'b1;
        nval = 0;
        repeat (20) begin
            tick();
            if (o_valid) nval++;
        end
        check_eq("rst_mid_stale", nval, 32'd0);
        check_eq("rst_mid_hold_x", o_x, 32'd0);
        send_one("post_rst", q(1.0), 32'd0, q(60.0), 0.5, 0.8660254, 0.01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
